// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ byte producers.
// Optional watchdog abort of a stalled frame is enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_p_data,
  output logic                 tx_data_valid,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 arb_busy,
  output logic                 err_timeout
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_rr_ptr_nxt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  w_ack_nxt;
  logic [7:0]          r_p_data;
  logic [7:0]          w_p_data_nxt;
  logic                r_dv;
  logic                w_dv_nxt;
  logic [ID_W-1:0]     r_grant;
  logic [ID_W-1:0]     w_grant_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_err;
  logic                w_err_nxt;

  logic [7:0]          w_req_byte [NUM_REQ];
  logic [ID_W-1:0]     w_scan;
  logic [ID_W-1:0]     w_win;
  logic                w_found;
  logic                w_launch;
  logic                w_timeout;
  logic                w_exit;

  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 131071) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYC must fit the 17-bit watchdog");
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_byte[g] = req_data[8*g +: 8];
  end

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Scan starts at the round-robin pointer and wraps modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = r_rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
      w_scan = next_id(w_scan);
    end
  end

  assign w_launch = (r_state == S_IDLE) && w_found && !tx_busy;
  assign w_exit   = (r_state == S_WAIT_DONE) && (tx_done || w_timeout);

`ifdef UART_TX_TIMEOUT_EN
  logic [16:0] r_wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (w_launch) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT_DONE) begin
      r_wd_cnt <= r_wd_cnt + 17'd1;
    end
  end

  // A tx_done on the expiry edge wins and ends the frame normally.
  assign w_timeout = (r_state == S_WAIT_DONE) && !tx_done &&
                     (r_wd_cnt == 17'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_launch) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (w_exit)   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt    = '0;
    w_dv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    w_p_data_nxt = r_p_data;
    w_grant_nxt  = r_grant;
    w_busy_nxt   = r_busy;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_ack_nxt[w_win] = 1'b1;
          w_dv_nxt         = 1'b1;
          w_p_data_nxt     = w_req_byte[w_win];
          w_grant_nxt      = w_win;
          w_busy_nxt       = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (w_exit) begin
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = next_id(r_grant);
          w_err_nxt    = w_timeout;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_ack    <= '0;
      r_p_data <= 8'h00;
      r_dv     <= 1'b0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
      r_ack    <= w_ack_nxt;
      r_p_data <= w_p_data_nxt;
      r_dv     <= w_dv_nxt;
      r_grant  <= w_grant_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign req_ack       = r_ack;
  assign tx_p_data     = r_p_data;
  assign tx_data_valid = r_dv;
  assign grant_id      = r_grant;
  assign arb_busy      = r_busy;
  assign err_timeout   = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 200;
`ifdef UART_TX_TIMEOUT_EN
  localparam int FRAME_CYC   = 150;
`else
  localparam int FRAME_CYC   = 52080;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_p_data;
  logic                 tx_data_valid;
  logic                 tx_busy;
  logic                 tx_done;
  logic [ID_W-1:0]      grant_id;
  logic                 arb_busy;
  logic                 err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .tx_p_data    (tx_p_data),
    .tx_data_valid(tx_data_valid),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       busy;
    logic       done;
    logic [3:0] ack;
    logic       dv;
    logic [7:0] data;
    logic [1:0] grant;
    logic       abusy;
  } vec_t;

  vec_t vecs [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_dv(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (tx_data_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Expects a launch, checks it, holds the frame for `delay` cycles and releases it.
  task automatic run_frame(input string tag, input int exp_id, input logic [7:0] exp_data,
                           input int delay, input logic [3:0] valid_after);
    logic ok;
    int   n_bad;
    wait_dv(50, ok);
    chk({tag, "_launch"}, 32'(ok), 32'd1);
    chk({tag, "_ack"}, 32'(req_ack), 32'(4'b0001 << exp_id));
    chk({tag, "_data"}, 32'(tx_p_data), 32'(exp_data));
    chk({tag, "_grant"}, 32'(grant_id), 32'(exp_id));
    req_valid = valid_after;
    n_bad = 0;
    for (int i = 1; i < delay; i++) begin
      tick();
      if (!arb_busy || tx_data_valid || req_ack != '0 || tx_p_data != exp_data) n_bad++;
    end
    chk({tag, "_hold"}, 32'(n_bad), 32'd0);
    done_pulse();
    chk({tag, "_release"}, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic ok;
    int   n_bad;
    logic exp_err;
    logic exp_busy;

    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    //         rst  valid  busy done ack    dv    data   grant abusy
    vecs[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'hE, 1'b0, 1'b0, 4'h0, 1'b0, 8'h10, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 4'hE, 1'b0, 1'b1, 4'h0, 1'b0, 8'h10, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'hE, 1'b0, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 4'hC, 1'b0, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0};
    vecs[7]  = '{1'b0, 4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 4'hC, 1'b0, 1'b0, 4'h4, 1'b1, 8'h12, 2'd2, 1'b1};
    vecs[9]  = '{1'b0, 4'h8, 1'b0, 1'b1, 4'h0, 1'b0, 8'h12, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'h8, 1'b0, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3, 1'b1};
    vecs[11] = '{1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h13, 2'd3, 1'b1};
    vecs[12] = '{1'b0, 4'h1, 1'b0, 1'b1, 4'h0, 1'b0, 8'h13, 2'd3, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h13, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 4'h3, 1'b0, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
    vecs[15] = '{1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 4'h2, 1'b0, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0};
    vecs[18] = '{1'b0, 4'h3, 1'b0, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};

    rst = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done = 1'b0;
    #1;
    foreach (vecs[k]) begin
      rst = vecs[k].rst; req_valid = vecs[k].valid;
      tx_busy = vecs[k].busy; tx_done = vecs[k].done;
      tick();
      chk($sformatf("vec%0d", k),
          32'({req_ack, tx_data_valid, tx_p_data, grant_id, arb_busy, err_timeout}),
          32'({vecs[k].ack, vecs[k].dv, vecs[k].data, vecs[k].grant, vecs[k].abusy, 1'b0}));
    end

    // Long reset with every requester pending.
    rst = 1'b1; req_valid = 4'hF; tx_busy = 1'b0; tx_done = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({req_ack, tx_data_valid, tx_p_data, grant_id, arb_busy, err_timeout} != '0) n_bad++;
    end
    chk("reset_outputs_zero", 32'(n_bad), 32'd0);
    rst = 1'b0;
    tick();
    chk("reset_first_ack", 32'(req_ack), 32'h1);
    req_valid = '0;
    done_pulse();

    // Single requester held for a full frame.
    do_reset();
    req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_valid = 4'b0100;
    run_frame("single", 2, 8'hA5, FRAME_CYC, 4'b0000);

    // Round robin with all four requesters pending.
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    run_frame("rr0", 0, 8'h10, 100, 4'hF);
    run_frame("rr1", 1, 8'h11, 100, 4'hF);
    run_frame("rr2", 2, 8'h12, 100, 4'hF);
    run_frame("rr3", 3, 8'h13, 100, 4'hF);
    run_frame("rr4", 0, 8'h10, 100, 4'h0);

    // Transmitter busy gates the launch.
    do_reset();
    tx_busy = 1'b1; req_valid = 4'b0001;
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_ack != '0 || tx_data_valid || arb_busy) n_bad++;
    end
    chk("busy_gate_quiet", 32'(n_bad), 32'd0);
    tx_busy = 1'b0;
    tick();
    chk("busy_gate_launch", 32'({tx_data_valid, req_ack}), 32'({1'b1, 4'b0001}));
    req_valid = '0;
    done_pulse();

    // Request arriving during WAIT_DONE is deferred until IDLE.
    do_reset();
    req_valid = 4'b0010;
    wait_dv(10, ok);
    chk("late_first_grant", 32'({ok, grant_id}), 32'({1'b1, 2'd1}));
    req_valid = 4'b1000;
    n_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (req_ack != '0 || tx_data_valid || !arb_busy) n_bad++;
    end
    chk("late_ignored", 32'(n_bad), 32'd0);
    done_pulse();
    chk("late_idle", 32'({arb_busy, req_ack}), 32'h0);
    tick();
    chk("late_grant", 32'({req_ack, grant_id, tx_p_data}), 32'({4'b1000, 2'd3, 8'h13}));
    req_valid = '0;
    done_pulse();

    // Frame whose tx_done never arrives.
    do_reset();
    req_valid = 4'b0001;
    wait_dv(10, ok);
    chk("wd_launch", 32'(ok), 32'd1);
    req_valid = '0;
    n_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
`ifdef UART_TX_TIMEOUT_EN
      exp_err  = (k == TIMEOUT_CYC);
      exp_busy = (k < TIMEOUT_CYC);
`else
      exp_err  = 1'b0;
      exp_busy = 1'b1;
`endif
      if (err_timeout !== exp_err || arb_busy !== exp_busy) n_bad++;
    end
    chk("wd_profile", 32'(n_bad), 32'd0);
`ifdef UART_TX_TIMEOUT_EN
    req_valid = 4'b0011;
    wait_dv(10, ok);
    chk("wd_next_grant", 32'({ok, grant_id}), 32'({1'b1, 2'd1}));
    req_valid = '0;
    done_pulse();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one UART_TX_TOP instance among NUM_REQ byte producers.
- Accepts byte requests over a valid/ack handshake.
- Drives the transmitter's p_data/data_valid inputs, then holds the grant until the transmitter reports uart_tx_done.
- Sits between the system-side producers (register block, debug logger, etc.) and UART_TX_TOP.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles (UART_TX_TIMEOUT_EN only); must exceed one frame (10 x 5208 = 52080).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high with data stable until acked.
- req_data  in  8*NUM_REQ  byte for requester i at [8*i+7:8*i].
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse; byte accepted.
- tx_p_data  out  8  to UART_TX_TOP p_data.
- tx_data_valid  out  1  to UART_TX_TOP data_valid; one-cycle pulse.
- tx_busy  in  1  from UART_TX_TOP busy.
- tx_done  in  1  from UART_TX_TOP uart_tx_done; one-cycle pulse at frame end.
- grant_id  out  ID_W  index of the current/last granted requester.
- arb_busy  out  1  high while a frame is owned (state WAIT_DONE).
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge, from any state):
  - state=IDLE, rr_ptr=0.
  - req_ack=0, tx_p_data=8'h00, tx_data_valid=0, grant_id=0, arb_busy=0, err_timeout=0, watchdog count=0.
- Two states: IDLE and WAIT_DONE.
- IDLE: at an edge where any req_valid=1 and tx_busy=0:
  - w = first set req_valid index searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: tx_p_data=req_data[w], tx_data_valid=1, req_ack[w]=1, grant_id=w, arb_busy=1.
  - state goes to WAIT_DONE.
  - Latency is one cycle from the sampled request to the data_valid/ack pulse.
- IDLE with tx_busy=1: no launch, no ack. Requests wait.
- WAIT_DONE:
  - tx_data_valid and req_ack return to 0 after one cycle. tx_p_data and grant_id hold their values.
  - New req_valid assertions are ignored.
  - On an edge with tx_done=1: state goes to IDLE, arb_busy=0, rr_ptr=(grant_id+1) mod NUM_REQ.
  - The earliest next launch is the edge after the return to IDLE, i.e. there is one idle cycle between frames.
- tx_done while in IDLE: ignored.
- Fairness: a requester that holds req_valid is granted within NUM_REQ frames.
- Requester rules:
  - A requester may not drop req_valid or change its data before its ack; behaviour if it does is undefined.
  - After the ack, the requester may present a new byte on the next cycle.
- Reset mid-frame: the arbiter returns to IDLE immediately with no ack. The frame already in UART_TX_TOP is not recovered; the system resets both blocks together.

Optional Feature:
- Macro: UART_TX_TIMEOUT_EN.
- With the macro:
  - A 17-bit counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - If it reaches TIMEOUT_CYC-1 without tx_done: state goes to IDLE, arb_busy=0, err_timeout=1 for one cycle, and rr_ptr advances past grant_id.
  - tx_done on that same edge takes priority: normal exit, no error.
- Without the macro: no counter. WAIT_DONE waits indefinitely and err_timeout is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset/idle: rst=1 for 20 cycles with req_valid=4'hF.
  - Response: all outputs 0, no tx_data_valid.
  - After rst=0, the first ack goes to requester 0.
- Single requester: req_valid=4'b0100, req_data[23:16]=8'hA5, model UART asserts tx_done 52080 cycles later.
  - Response: one tx_data_valid pulse with tx_p_data=8'hA5, req_ack=4'b0100, grant_id=2.
  - arb_busy=1 until the tx_done edge.
- Round-robin: all four requesters hold valid with bytes 8'h10, 8'h11, 8'h12, 8'h13, tx_done 100 cycles after each launch.
  - Response: grant order 0,1,2,3,0. Each requester receives exactly one ack per four frames.
- Busy gating: tx_busy=1 while req_valid=4'b0001.
  - Response: no ack and no data_valid. Launch occurs one cycle after tx_busy falls.
- Late request: req_valid[3] rises during WAIT_DONE of requester 1.
  - Response: ignored until IDLE, then granted next. Stray tx_done in IDLE produces no state change.
- Watchdog (UART_TX_TIMEOUT_EN, TIMEOUT_CYC=200): launch, never assert tx_done.
  - Response: err_timeout pulses exactly 200 cycles after the launch, then the next requester is granted.
  - Without the macro: arb_busy stays high indefinitely.
